// File: rtl/writeback_rf.sv
// writeback_rf: bf8b writeback stage owning the register file.
// Three-cycle handshake, bypassed read ports, busy scoreboard.
module writeback_rf #(
   parameter int         DATA_W   = 8,
   parameter int         NUM_REGS = 16,
   parameter int         ADDR_W   = 4,
   parameter logic [1:0] OP_LOD   = 2'b01,
   parameter logic [1:0] OP_ADD   = 2'b11,
   parameter bit         ZERO_R0  = 1'b0
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [1:0]          in_op,
   input  logic [ADDR_W-1:0]   in_addr,
   input  logic [DATA_W-1:0]   in_val,
   input  logic [ADDR_W-1:0]   rd_addr_a,
   output logic [DATA_W-1:0]   rd_data_a,
   input  logic [ADDR_W-1:0]   rd_addr_b,
   output logic [DATA_W-1:0]   rd_data_b,
   output logic [NUM_REGS-1:0] busy,
   output logic                zero_flag,
   output logic                done
);

   localparam int NA = 2 ** ADDR_W;

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_COMMIT = 2'd1;
   localparam logic [1:0] S_DONE   = 2'd2;

   logic [1:0]        state;
   logic [1:0]        h_op;
   logic [ADDR_W-1:0] h_addr;
   logic [DATA_W-1:0] h_val;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic [NA-1:0]     in_range;
   logic              in_q;
   logic              hold_q;
   logic              accept;

   // Constant map of addresses that name a real register
   always_comb begin
      in_range = '0;
      for (int i = 0; i < NA; i++)
         in_range[i] = (i < NUM_REGS);
   end

   // Qualification of incoming and held writes
   always_comb begin
      in_q = (in_op == OP_LOD || in_op == OP_ADD)
          && in_range[in_addr]
          && !(ZERO_R0 && in_addr == '0);
      hold_q = (h_op == OP_LOD || h_op == OP_ADD)
          && in_range[h_addr]
          && !(ZERO_R0 && h_addr == '0);
   end

   assign in_ready = (state == S_IDLE) && !rst;
   assign accept   = in_valid && in_ready;

   // Capture the transaction into hold registers on acceptance
   always_ff @(posedge clk) begin
      if (accept) begin
         h_op   <= in_op;
         h_addr <= in_addr;
         h_val  <= in_val;
      end
   end

   // Handshake FSM, busy scoreboard, zero flag and done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_IDLE;
         busy      <= '0;
         zero_flag <= 1'b0;
         done      <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (in_valid) begin
                  state <= S_COMMIT;
                  if (in_q)
                     busy[in_addr] <= 1'b1;
               end
            end
            S_COMMIT: begin
               if (h_op == OP_ADD)
                  zero_flag <= (h_val == '0);
               busy  <= '0;
               done  <= 1'b1;
               state <= S_DONE;
            end
            S_DONE: begin
               done  <= 1'b0;
               state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   // Register storage, written in the commit cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_REGS; i++)
            regs[i] <= '0;
      end else if (state == S_COMMIT && hold_q) begin
         regs[h_addr] <= h_val;
      end
   end

   // Read port A with range, R0 and commit bypass handling
   always_comb begin
      rd_data_a = '0;
      if (!in_range[rd_addr_a])
         rd_data_a = '0;
      else if (ZERO_R0 && rd_addr_a == '0)
         rd_data_a = '0;
      else if (state == S_COMMIT && hold_q && rd_addr_a == h_addr)
         rd_data_a = h_val;
      else
         rd_data_a = regs[rd_addr_a];
   end

   // Read port B, same rules as port A
   always_comb begin
      rd_data_b = '0;
      if (!in_range[rd_addr_b])
         rd_data_b = '0;
      else if (ZERO_R0 && rd_addr_b == '0)
         rd_data_b = '0;
      else if (state == S_COMMIT && hold_q && rd_addr_b == h_addr)
         rd_data_b = h_val;
      else
         rd_data_b = regs[rd_addr_b];
   end

endmodule

// File: tb/tb_writeback_rf.sv
// tb_writeback_rf: directed bench for writeback_rf.
// Timing model plus literal checks; second instance covers R0/range.
module tb_writeback_rf;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic [1:0]  in_op;
   logic [3:0]  in_addr;
   logic [7:0]  in_val;
   logic [3:0]  rd_addr_a;
   logic [3:0]  rd_addr_b;

   logic        in_ready, zero_flag, done;
   logic [7:0]  rd_data_a, rd_data_b;
   logic [15:0] busy;

   logic        in_ready1, zero_flag1, done1;
   logic [7:0]  rd_data_a1, rd_data_b1;
   logic [11:0] busy1;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   writeback_rf u0 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_addr(in_addr), .in_val(in_val),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a),
      .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b),
      .busy(busy), .zero_flag(zero_flag), .done(done)
   );

   writeback_rf #(.NUM_REGS(12), .ZERO_R0(1'b1)) u1 (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready1),
      .in_op(in_op), .in_addr(in_addr), .in_val(in_val),
      .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a1),
      .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b1),
      .busy(busy1), .zero_flag(zero_flag1), .done(done1)
   );

   // ---------------- behavioural model ----------------
   // age = cycles since the last accepted transaction (0 = commit pending)
   int         age = 2;
   bit         started = 0;
   logic [7:0] m_regs [16];
   logic       m_zf;
   logic [1:0] m_op;
   logic [3:0] m_addr;
   logic [7:0] m_val;
   time        acc_t [$];

   function automatic bit m_wr(input logic [1:0] op);
      return op == 2'b01 || op == 2'b11;
   endfunction

   function automatic logic [7:0] m_rd(input logic [3:0] a);
      if (age == 0 && m_wr(m_op) && a == m_addr) return m_val;
      return m_regs[a];
   endfunction

   function automatic logic [7:0] m_rd1(input logic [3:0] a);
      if (a == 0 || a >= 12) return 8'h00;
      return m_rd(a);
   endfunction

   always @(posedge clk) begin
      started = 1;
      if (rst) begin
         age = 2;
         m_zf = 1'b0;
         for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
      end else begin
         if (age == 0) begin
            if (m_wr(m_op)) m_regs[m_addr] = m_val;
            if (m_op == 2'b11) m_zf = (m_val == 8'h00);
         end
         if (age >= 2 && in_valid) begin
            m_op = in_op; m_addr = in_addr; m_val = in_val;
            age = 0;
         end else if (age < 2) begin
            age++;
         end
      end
   end

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      if (started) begin
         logic [15:0] eb;
         logic [11:0] eb1;
         eb  = '0;
         eb1 = '0;
         if (age == 0 && m_wr(m_op)) begin
            eb[m_addr] = 1'b1;
            if (m_addr != 0 && m_addr < 12) eb1[m_addr] = 1'b1;
         end
         chk("in_ready",  in_ready,  !rst && age >= 2);
         chk("done",      done,      age == 1);
         chk("busy",      busy,      eb);
         chk("zero_flag", zero_flag, m_zf);
         chk("rd_data_a", rd_data_a, m_rd(rd_addr_a));
         chk("rd_data_b", rd_data_b, m_rd(rd_addr_b));
         chk("u1_ready",  in_ready1, !rst && age >= 2);
         chk("u1_done",   done1,     age == 1);
         chk("u1_busy",   busy1,     eb1);
         chk("u1_zf",     zero_flag1, m_zf);
         chk("u1_rd_a",   rd_data_a1, m_rd1(rd_addr_a));
         chk("u1_rd_b",   rd_data_b1, m_rd1(rd_addr_b));
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
      #1;
   endtask

   // Presents one result and holds valid until accepted; returns in COMMIT
   task automatic txn(input logic [1:0] op, input logic [3:0] a,
                      input logic [7:0] v);
      bit acc;
      acc = 0;
      in_valid = 1'b1; in_op = op; in_addr = a; in_val = v;
      for (int i = 0; i < 8 && !acc; i++) begin
         #1 acc = in_ready;
         @(negedge clk);
         #1;
      end
      in_valid = 1'b0;
      n_vec++;
      if (!acc) begin
         n_err++;
         $display("FAIL accept_timeout: op %b addr %0d not accepted", op, a);
      end else begin
         acc_t.push_back($time);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_op = 2'b00;
      in_addr = 4'd0; in_val = 8'h00;
      rd_addr_a = 4'd0; rd_addr_b = 4'd0;
      repeat (3) @(negedge clk);
      #1 rst = 1'b0;
      #1;

      // 1: reset state on every address
      chk("t1_busy", busy, 16'h0000);
      chk("t1_zf", zero_flag, 1'b0);
      chk("t1_done", done, 1'b0);
      chk("t1_ready", in_ready, 1'b1);
      for (int i = 0; i < 16; i++) begin
         rd_addr_a = 4'(i);
         rd_addr_b = 4'(15 - i);
         #1;
         chk("t1_rd_a", rd_data_a, 8'h00);
         chk("t1_rd_b", rd_data_b, 8'h00);
         chk("t1_u1_rd_a", rd_data_a1, 8'h00);
      end
      step();

      // 2: LOD R5 with bypass, busy and done pulse
      txn(2'b01, 4'd5, 8'hA7);
      rd_addr_a = 4'd5;
      #1;
      chk("t2_bypass", rd_data_a, 8'hA7);
      chk("t2_busy", busy, 16'h0020);
      chk("t2_ready", in_ready, 1'b0);
      step();
      chk("t2_done", done, 1'b1);
      chk("t2_busy_clr", busy, 16'h0000);
      chk("t2_stored", rd_data_a, 8'hA7);
      step();
      chk("t2_done_low", done, 1'b0);
      chk("t2_ready_back", in_ready, 1'b1);

      // 3: zero flag from ADD; non-write op leaves state alone
      rd_addr_a = 4'd3;
      txn(2'b11, 4'd3, 8'h00);
      step(); step();
      chk("t3_zf_set", zero_flag, 1'b1);
      txn(2'b11, 4'd3, 8'h01);
      step(); step();
      chk("t3_zf_clr", zero_flag, 1'b0);
      chk("t3_r3", rd_data_a, 8'h01);
      txn(2'b10, 4'd3, 8'hFF);
      chk("t3_nowr_busy", busy, 16'h0000);
      chk("t3_nowr_byp", rd_data_a, 8'h01);
      step();
      chk("t3_nowr_done", done, 1'b1);
      step();
      chk("t3_r3_kept", rd_data_a, 8'h01);
      chk("t3_zf_kept", zero_flag, 1'b0);

      // 4: back-to-back LODs, valid never dropped
      acc_t.delete();
      for (int k = 0; k < 4; k++)
         txn(2'b01, 4'(8 + k), 8'((k + 1) * 16 + k));
      step(); step();
      for (int k = 1; k < 4; k++)
         chk("t4_spacing", 32'(acc_t[k] - acc_t[k-1]), 32'd30);
      rd_addr_a = 4'd8; rd_addr_b = 4'd9;
      #1;
      chk("t4_r8", rd_data_a, 8'h10);
      chk("t4_r9", rd_data_b, 8'h21);
      rd_addr_a = 4'd10; rd_addr_b = 4'd11;
      #1;
      chk("t4_r10", rd_data_a, 8'h32);
      chk("t4_r11", rd_data_b, 8'h43);
      step();

      // 5: R0 gating and out-of-range drop on the 12-reg instance
      rd_addr_a = 4'd0; rd_addr_b = 4'd14;
      txn(2'b01, 4'd0, 8'hFF);
      #1;
      chk("t5_u1_r0_busy", busy1, 12'h000);
      chk("t5_u1_r0_rd", rd_data_a1, 8'h00);
      chk("t5_u0_r0_byp", rd_data_a, 8'hFF);
      step();
      chk("t5_u1_r0_done", done1, 1'b1);
      step();
      txn(2'b01, 4'd14, 8'h77);
      chk("t5_u1_r14_busy", busy1, 12'h000);
      step(); step();
      chk("t5_u1_r14_rd", rd_data_b1, 8'h00);
      chk("t5_u0_r14_rd", rd_data_b, 8'h77);

      // 6: reset during commit discards the write
      rd_addr_a = 4'd2;
      txn(2'b01, 4'd2, 8'h55);
      #1;
      chk("t6_bypass", rd_data_a, 8'h55);
      rst = 1'b1;
      step();
      chk("t6_done", done, 1'b0);
      chk("t6_busy", busy, 16'h0000);
      chk("t6_ready_rst", in_ready, 1'b0);
      rst = 1'b0;
      #1;
      chk("t6_ready", in_ready, 1'b1);
      chk("t6_r2", rd_data_a, 8'h00);
      step(); step();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
